// File: rtl/dmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_arbiter
// Description : Round-robin arbiter sharing one data-memory port among four
//               processor nodes, with registered issue slot and read return.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req_en,
    input  logic [3:0]            req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_2,
    input  logic [ADDR_WIDTH-1:0] req_addr_3,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_2,
    input  logic [DATA_WIDTH-1:0] req_wdata_3,
    output logic [3:0]            gnt,
    output logic [3:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int c_NODES = 4;

    logic [1:0]            r_ptr;
    logic [1:0]            r_tag;
    logic                  w_slot_free;
    logic                  w_found;
    logic                  w_grant;
    logic [1:0]            w_sel;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0] w_wdata_sel;

    // The slot frees either when empty or when its request retires this edge.
    assign w_slot_free = !mem_en || mem_ready;

    // Search starts at the priority pointer and wraps modulo four.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int i = 0; i < c_NODES; i++) begin
            if (!w_found && req_en[r_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_sel   = r_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        w_addr_sel  = req_addr_0;
        w_wdata_sel = req_wdata_0;
        case (w_sel)
            2'd1: begin
                w_addr_sel  = req_addr_1;
                w_wdata_sel = req_wdata_1;
            end
            2'd2: begin
                w_addr_sel  = req_addr_2;
                w_wdata_sel = req_wdata_2;
            end
            2'd3: begin
                w_addr_sel  = req_addr_3;
                w_wdata_sel = req_wdata_3;
            end
            default: begin
                w_addr_sel  = req_addr_0;
                w_wdata_sel = req_wdata_0;
            end
        endcase
    end

    assign w_grant = w_slot_free && w_found && !reset;
    assign gnt     = w_grant ? (4'b0001 << w_sel) : 4'b0000;
    assign rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rvalid    <= 4'b0000;
            r_tag     <= 2'd0;
            r_ptr     <= 2'd0;
        end else begin
            rvalid <= (mem_en && !mem_wr_en && mem_ready) ? (4'b0001 << r_tag) : 4'b0000;
            if (w_slot_free) begin
                if (w_grant) begin
                    mem_en    <= 1'b1;
                    mem_wr_en <= req_wr[w_sel];
                    mem_addr  <= w_addr_sel;
                    mem_wdata <= w_wdata_sel;
                    r_tag     <= w_sel;
                    r_ptr     <= w_sel + 2'd1;
                end else begin
                    // Address and data registers intentionally hold when idle.
                    mem_en    <= 1'b0;
                    mem_wr_en <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_rr_arbiter
// Description : Self-checking bench for dmem_rr_arbiter with a scoreboard of
//               expected issues and read returns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_rr_arbiter;

    typedef struct packed {
        logic [1:0]  node;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_en;
    logic [3:0]  req_wr;
    logic [31:0] a [4];
    logic [63:0] wd [4];
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [63:0] rdata;
    logic        mem_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata = 64'd0;

    logic [63:0] mem [logic [31:0]];

    txn_t        issue_q [$];
    txn_t        cur;
    bit          cur_v = 1'b0;
    bit          prev_gnt = 1'b0;
    logic [3:0]  exp_rv = 4'b0000;
    logic [63:0] exp_rd = 64'd0;
    int          checks = 0;
    int          passed = 0;

    dmem_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_en     (req_en),
        .req_wr     (req_wr),
        .req_addr_0 (a[0]),
        .req_addr_1 (a[1]),
        .req_addr_2 (a[2]),
        .req_addr_3 (a[3]),
        .req_wdata_0(wd[0]),
        .req_wdata_1(wd[1]),
        .req_wdata_2(wd[2]),
        .req_wdata_3(wd[3]),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] v;
        v = 4'b0001 << k;
        return v;
    endfunction

    function automatic logic [63:0] mem_val(input logic [31:0] ad);
        if (mem.exists(ad)) return mem[ad];
        return {~ad, ad};
    endfunction

    // Synchronous-read memory behind the shared port.
    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_ready === 1'b1) begin
            if (mem_wr_en) mem[mem_addr] = mem_wdata;
            else mem_rdata <= mem_val(mem_addr);
        end
    end

    function automatic txn_t mk(input int k, input logic wr);
        txn_t t;
        t.node  = 2'(k);
        t.wr    = wr;
        t.addr  = a[k];
        t.wdata = wd[k];
        return t;
    endfunction

    // Scoreboard: issues expected by the tasks are popped the cycle after a grant.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            issue_q.delete();
            cur_v    = 1'b0;
            prev_gnt = 1'b0;
            exp_rv   = 4'b0000;
        end else begin
            checks++;
            if (rvalid !== exp_rv) $display("FAIL sb_rvalid: got %b expected %b", rvalid, exp_rv);
            else passed++;
            if (exp_rv != 4'b0000) begin
                checks++;
                if (rdata !== exp_rd) $display("FAIL sb_rdata: got %h expected %h", rdata, exp_rd);
                else passed++;
            end
            exp_rv = 4'b0000;
            if (prev_gnt) begin
                if (issue_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_issue: got grant expected none queued");
                end else begin
                    cur   = issue_q.pop_front();
                    cur_v = 1'b1;
                end
            end
            checks++;
            if (cur_v) begin
                if (mem_en !== 1'b1 || mem_wr_en !== cur.wr || mem_addr !== cur.addr || mem_wdata !== cur.wdata)
                    $display("FAIL sb_mem: got en=%b wr=%b addr=%h wdata=%h expected en=1 wr=%b addr=%h wdata=%h",
                             mem_en, mem_wr_en, mem_addr, mem_wdata, cur.wr, cur.addr, cur.wdata);
                else passed++;
                if (mem_ready) begin
                    if (!cur.wr) begin
                        exp_rv = onehot(int'(cur.node));
                        exp_rd = mem_val(cur.addr);
                    end
                    cur_v = 1'b0;
                end
            end else begin
                if (mem_en !== 1'b0) $display("FAIL sb_idle: got mem_en=%b expected 0", mem_en);
                else passed++;
            end
            prev_gnt = (gnt != 4'b0000);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_en = 4'hF; req_wr = 4'h0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a[i]  = 32'h0;
            wd[i] = 64'h0;
        end
        tick();
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt); else passed++;
        checks++;
        if (mem_en !== 1'b0 || mem_wr_en !== 1'b0) $display("FAIL reset_en: got en=%b wr=%b expected 0 0", mem_en, mem_wr_en); else passed++;
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 64'h0) $display("FAIL reset_regs: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); else passed++;
        checks++;
        if (rvalid !== 4'b0000) $display("FAIL reset_rvalid: got %b expected 0000", rvalid); else passed++;
        tick();
        reset = 1'b0; req_en = 4'h0;
        tick();
    endtask

    task automatic test_single_read();
        a[2] = 32'h100;
        mem[32'h100] = 64'hDEAD_BEEF_0000_0001;
        req_en = 4'b0100; req_wr = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) $display("FAIL read_gnt: got %b expected 0100", gnt); else passed++;
        issue_q.push_back(mk(2, 1'b0));
        tick();
        req_en = 4'b0000;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h100) $display("FAIL read_issue: got en=%b addr=%h expected 1 100", mem_en, mem_addr); else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (rvalid !== 4'b0100 || rdata !== 64'hDEAD_BEEF_0000_0001)
            $display("FAIL read_return: got rvalid=%b rdata=%h expected 0100 deadbeef00000001", rvalid, rdata);
        else passed++;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = 32'h200 + 32'(i * 8);
            wd[i] = 64'hF000 + 64'(i);
        end
        req_en = 4'hF; req_wr = 4'h0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (gnt !== onehot(n % 4)) $display("FAIL fair_gnt%0d: got %b expected %b", n, gnt, onehot(n % 4)); else passed++;
            issue_q.push_back(mk(n % 4, 1'b0));
            if (n > 0) begin
                checks++;
                if (mem_en !== 1'b1) $display("FAIL fair_busy%0d: got mem_en=%b expected 1", n, mem_en); else passed++;
            end
            tick();
        end
        req_en = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_pointer_skip();
        a[1] = 32'h510; a[3] = 32'h530;
        req_en = 4'b1010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) $display("FAIL skip_first: got %b expected 1000", gnt); else passed++;
        issue_q.push_back(mk(3, 1'b0));
        tick();
        req_en = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) $display("FAIL skip_second: got %b expected 0010", gnt); else passed++;
        issue_q.push_back(mk(1, 1'b0));
        tick();
        req_en = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_stall();
        a[1] = 32'h300; a[3] = 32'h340;
        req_en = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) $display("FAIL stall_gnt1: got %b expected 0010", gnt); else passed++;
        issue_q.push_back(mk(1, 1'b0));
        tick();
        req_en = 4'b1000; mem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || rvalid !== 4'b0000 || mem_addr !== 32'h300)
                $display("FAIL stall_hold%0d: got gnt=%b rvalid=%b addr=%h expected 0000 0000 300", s, gnt, rvalid, mem_addr);
            else passed++;
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) $display("FAIL stall_gnt3: got %b expected 1000", gnt); else passed++;
        issue_q.push_back(mk(3, 1'b0));
        tick();
        req_en = 4'b0000;
        @(negedge clk);
        checks++;
        if (rvalid !== 4'b0010) $display("FAIL stall_rvalid: got %b expected 0010", rvalid); else passed++;
        tick();
        tick();
        tick();
    endtask

    task automatic test_write();
        a[0] = 32'h40; wd[0] = 64'h1234;
        req_en = 4'b0001; req_wr = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) $display("FAIL write_gnt: got %b expected 0001", gnt); else passed++;
        issue_q.push_back(mk(0, 1'b1));
        tick();
        req_en = 4'b0000; req_wr = 4'b1111;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wdata !== 64'h1234) $display("FAIL write_issue: got wr=%b wdata=%h expected 1 1234", mem_wr_en, mem_wdata); else passed++;
        tick();
        a[2] = 32'h40; wd[2] = 64'h77;
        req_en = 4'b0100; req_wr = 4'b1011;
        @(negedge clk);
        checks++;
        if (rvalid !== 4'b0000) $display("FAIL write_no_rvalid: got %b expected 0000", rvalid); else passed++;
        checks++;
        if (gnt !== 4'b0100) $display("FAIL readback_gnt: got %b expected 0100", gnt); else passed++;
        issue_q.push_back(mk(2, 1'b0));
        tick();
        req_en = 4'b0000; req_wr = 4'b0000;
        tick();
        @(negedge clk);
        checks++;
        if (rvalid !== 4'b0100 || rdata !== 64'h1234) $display("FAIL readback_data: got rvalid=%b rdata=%h expected 0100 1234", rvalid, rdata); else passed++;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_read();
        a[0] = 32'h80;
        req_en = 4'b0001; req_wr = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) $display("FAIL rst_mid_gnt: got %b expected 0001", gnt); else passed++;
        issue_q.push_back(mk(0, 1'b0));
        tick();
        reset = 1'b1; req_en = 4'hF;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || gnt !== 4'b0000) $display("FAIL rst_mid_inflight: got en=%b gnt=%b expected 1 0000", mem_en, gnt); else passed++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || rvalid !== 4'b0000) $display("FAIL rst_mid_clear: got en=%b rvalid=%b expected 0 0000", mem_en, rvalid); else passed++;
        checks++;
        if (gnt !== 4'b0001) $display("FAIL rst_mid_ptr: got %b expected 0001", gnt); else passed++;
        issue_q.push_back(mk(0, 1'b0));
        tick();
        req_en = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_pointer_skip();
        test_stall();
        test_write();
        test_reset_mid_read();
        @(negedge clk);
        checks++;
        if (issue_q.size() != 0 || cur_v) $display("FAIL drain: got %0d queued expected 0", issue_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_rr_arbiter.md
# dmem_rr_arbiter

Round-robin arbiter that shares one data-memory port among the four processor nodes of the Cardinal CMP. Each node's data-memory request port (enable, write enable, address, write data) is a requester. The arbiter grants one request per cycle, registers it onto the shared memory port, and routes read data back to the originating node. It sits between the four `cardinal_cpu` dmem ports and a single shared, synchronous-read data memory.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: request and memory address width.
- `DATA_WIDTH`, default 64: write and read data width.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req_en`, input, 4: request valid. Bit i belongs to node i.
- `req_wr`, input, 4: per-node write flag. 1 = write, 0 = read. Valid only with `req_en[i]`.
- `req_addr_0` … `req_addr_3`, input, ADDR_WIDTH each: per-node address.
- `req_wdata_0` … `req_wdata_3`, input, DATA_WIDTH each: per-node write data.
- `gnt`, output, 4: one-hot grant. Combinational; high in the cycle the request is accepted.
- `rvalid`, output, 4: one-hot read-return strobe. Registered.
- `rdata`, output, DATA_WIDTH: read data. Passthrough of `mem_rdata`; meaningful only when `rvalid` is nonzero.
- `mem_en`, output, 1: shared memory request. Registered.
- `mem_wr_en`, output, 1: shared memory write. Registered.
- `mem_addr`, output, ADDR_WIDTH: shared memory address. Registered.
- `mem_wdata`, output, DATA_WIDTH: shared memory write data. Registered.
- `mem_ready`, input, 1: memory accepts the current `mem_*` request at this edge.
- `mem_rdata`, input, DATA_WIDTH: memory read data. Valid the cycle after a read is accepted.

## Operation

Requester rule:
- Node i holds `req_en[i]`, `req_wr[i]`, `req_addr_i` and `req_wdata_i` stable until it samples `gnt[i]`=1.
- It may drop or change the request in the cycle after the grant.

Issue slot:
- The issue slot is the `mem_*` register set plus `tag` (2 bits, the granted node index).
- The slot is free when `mem_en`=0, or when `mem_en`=1 and `mem_ready`=1 (the current request retires at this edge).

Arbitration:
- Arbitration happens only when the slot is free.
- Priority pointer `ptr` (2 bits): search starts at node `ptr` and proceeds `ptr`, `ptr+1`, … modulo 4. The first node with `req_en` set wins.
- On a grant to node k, `ptr` <= (k+1) mod 4.
- With no grant, `ptr` is unchanged.

Issue:
- On a grant to node k at edge E, load `mem_en`=1, `mem_wr_en`=`req_wr[k]`, `mem_addr`=`req_addr_k`, `mem_wdata`=`req_wdata_k`, `tag`=k.
- Slot free with no grant: `mem_en` <= 0 and `mem_wr_en` <= 0; the address and data registers hold.
- Slot not free (`mem_en`=1, `mem_ready`=0): all `mem_*` and `tag` hold, and `gnt`=0.

Read return:
- When `mem_en`=1, `mem_wr_en`=0 and `mem_ready`=1 at edge E, `rvalid` <= one-hot(`tag`) for exactly one cycle.
- In all other cases `rvalid` <= 0.
- Writes produce no `rvalid`.

## Timing

- Reset values: `mem_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, `rvalid`=0, `tag`=0, `ptr`=0. `gnt`=0 during reset.
- Reset mid-operation: any in-flight request and any pending read return are discarded. No `rvalid` is produced in the cycle after reset.
- Latency with `mem_ready`=1 throughout:
  - `gnt` in cycle T.
  - `mem_*` driven in cycle T+1.
  - `rvalid`/`rdata` in cycle T+2.
- Throughput: one grant per cycle, back-to-back, when `mem_ready`=1. A retirement and a new grant at the same edge is legal and required.
- `rvalid` for request n and `mem_en` for request n+1 coincide in the same cycle.
- Wrap-around: `ptr`=3 and a grant to node 3 gives `ptr`=0.
- `req_wr` is ignored for nodes whose `req_en` is 0.

## Test plan

1. Single read: node2 reads address 0x100, `mem_ready`=1, memory returns 0xDEAD_BEEF_0000_0001. Required: `gnt`=4'b0100 at T; `mem_en`=1, `mem_addr`=0x100 at T+1; `rvalid`=4'b0100 and `rdata`=0xDEAD_BEEF_0000_0001 at T+2.
2. Fairness: all four nodes request continuously after reset (`ptr`=0). Required: grant order 0,1,2,3,0,1, one per cycle, with no idle cycles on `mem_en`.
3. Stall: read from node1 issued, then `mem_ready`=0 for 3 cycles while node3 requests. Required: `mem_*` stable, `gnt`=0 and `rvalid`=0 during the stall. `rvalid[1]` appears the cycle after `mem_ready` returns to 1, and `gnt[3]` is asserted in that same `mem_ready`=1 cycle.
4. Write: node0 writes 0x1234 to address 0x40. Required: `mem_wr_en`=1, `mem_wdata`=0x1234 at T+1; `rvalid` remains 0 at T+2.
5. Pointer skip: last grant to node1 (`ptr`=2); nodes 1 and 3 request. Required: node3 is granted first, then node1.
6. Reset mid-read: `reset` is asserted in the cycle `mem_en`=1 for a node0 read. Required: the next cycle has `mem_en`=0, `rvalid`=0 and `ptr`=0.
